pdp11_irq_ctrl: RTL

PDP11_IRQ_CTRL -- requirements
Module: pdp11_irq_ctrl

---
 rtl/pdp11_irq_ctrl_if.sv | 11 +
 rtl/pdp11_irq_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/pdp11_irq_ctrl_if.sv
// CPU I/O register bus between the PDP-11 core (master) and the interrupt controller (slave).
// Read data is registered in the slave and may be OR-ed with other devices' read data.
interface pdp11_irq_ctrl_if;
    logic [7:0]  io_addr;
    logic [15:0] io_wdata;
    logic        io_wen;
    logic [15:0] io_rdata;

    modport master (output io_addr, output io_wdata, output io_wen, input io_rdata);
    modport slave  (input io_addr, input io_wdata, input io_wen, output io_rdata);
endinterface

// File: rtl/pdp11_irq_ctrl.sv
// Eight-line interrupt controller: synchronised sources, edge/level capture into PENDING,
// per-line masking and a memory-mapped register window with a priority readout.
module pdp11_irq_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'd32
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,
    pdp11_irq_ctrl_if.slave  bus,
    input  logic [7:0]       src_in,
    output logic [7:0]       int_reqs,
    input  logic [7:0]       int_ack
);

    logic [7:0]  s0_q, s1_q, prev_q;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  edge_q, edge_d;
    logic [7:0]  pend_q, pend_d;
    logic [15:0] rdata_q, rdata_d;

    logic [7:0]  off;
    logic        in_win;
    logic        wr_mask, wr_edge, wr_w1c, wr_swset;
    logic [7:0]  set_bits, clr_bits, active;
    logic [15:0] highest;

    // Only the low byte of write data reaches any register.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus.io_wdata[15:8];

    function automatic logic [2:0] highest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    assign off    = bus.io_addr - BASE_ADDR;
    assign in_win = (bus.io_addr >= BASE_ADDR) && (off <= 8'd5);

    assign wr_mask  = bus.io_wen && in_win && (off == 8'd0);
    assign wr_edge  = bus.io_wen && in_win && (off == 8'd1);
    assign wr_w1c   = bus.io_wen && in_win && (off == 8'd2);
    assign wr_swset = bus.io_wen && in_win && (off == 8'd3);

    assign active   = pend_q & mask_q;
    assign int_reqs = active;
    assign highest  = {|active, 12'h000, highest_idx(active)};

    assign set_bits = (edge_q & s1_q & ~prev_q)
                    | (~edge_q & s1_q)
                    | (wr_swset ? bus.io_wdata[7:0] : 8'h00);
    assign clr_bits = int_ack | (wr_w1c ? bus.io_wdata[7:0] : 8'h00);

    always_comb begin
        mask_d  = wr_mask ? bus.io_wdata[7:0] : mask_q;
        edge_d  = wr_edge ? bus.io_wdata[7:0] : edge_q;
        // A set source in the same cycle as a clear source keeps the bit pending.
        pend_d  = (pend_q & ~clr_bits) | set_bits;
        rdata_d = rdata_q;
        if (!bus.io_wen) begin
            rdata_d = 16'h0000;
            if (in_win) begin
                case (off)
                    8'd0:    rdata_d = {8'h00, mask_q};
                    8'd1:    rdata_d = {8'h00, edge_q};
                    8'd2:    rdata_d = {8'h00, pend_q};
                    8'd4:    rdata_d = highest;
                    8'd5:    rdata_d = {8'h00, s1_q};
                    default: rdata_d = 16'h0000;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            s0_q    <= 8'h00;
            s1_q    <= 8'h00;
            prev_q  <= 8'h00;
            mask_q  <= 8'h00;
            edge_q  <= 8'h00;
            pend_q  <= 8'h00;
            rdata_q <= 16'h0000;
        end else begin
            s0_q    <= src_in;
            s1_q    <= s0_q;
            prev_q  <= s1_q;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.io_rdata = rdata_q;

endmodule
